// File: rtl/y86_pipe_pkg.sv
// Shared Y86-64 pipeline encodings: icodes, ALU ops, condition codes,
// "no register" value and the NOP bubble contents of a pipeline register.
package y86_pipe_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [3:0] BUB_ICODE = I_NOP;
    localparam logic       BUB_CND   = 1'b0;
    localparam logic [3:0] BUB_DST   = RNONE;

    // cc is packed {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = (sf ^ of) | zf;
            C_L:     cond_eval = sf ^ of;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = ~zf;
            C_GE:    cond_eval = ~(sf ^ of);
            C_G:     cond_eval = ~(sf ^ of) & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = B op A, plus the flags a CC update would take.
module y86_alu
    import y86_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [3:0]   alu_fun,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                result = alu_b + alu_a;
                of     = (alu_a[W-1] == alu_b[W-1]) && (result[W-1] != alu_a[W-1]);
            end
            ALU_SUB: begin
                result = alu_b - alu_a;
                of     = (alu_a[W-1] != alu_b[W-1]) && (result[W-1] != alu_b[W-1]);
            end
            ALU_AND: result = alu_b & alu_a;
            ALU_XOR: result = alu_b ^ alu_a;
            default: result = '0;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[W-1];

endmodule

// File: rtl/exec_mreg_pipe.sv
// Y86-64 execute stage with CC register and the M pipeline register.
// Optional counters enabled by defining EXEC_PERF_EN.
module exec_mreg_pipe
    import y86_pipe_pkg::*;
#(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = y86_pipe_pkg::RNONE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic         m_exc,
    input  logic         W_exc,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
`ifdef EXEC_PERF_EN
    output logic [31:0]  perf_opq,
    output logic [31:0]  perf_cmov_sq,
`endif
    output logic [2:0]   cc
);

    localparam logic [W-1:0] POS8 = W'(8);
    localparam logic [W-1:0] NEG8 = '0 - POS8;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_fun;
    logic         new_zf, new_sf, new_of;
    logic         set_cc;

    logic [2:0]   cc_reg;
    logic [3:0]   m_icode_reg;
    logic         m_cnd_reg;
    logic [W-1:0] m_vale_reg;
    logic [W-1:0] m_vala_reg;
    logic [3:0]   m_dste_reg;
    logic [3:0]   m_dstm_reg;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = NEG8;
            I_RET, I_POPQ:               alu_a = POS8;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default:                                                 alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    y86_alu #(.W(W)) u_alu (
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_fun (alu_fun),
        .result  (e_valE),
        .zf      (new_zf),
        .sf      (new_sf),
        .of      (new_of)
    );

    // Conditions look at the committed flags, never the ones being computed now.
    assign e_Cnd  = ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) ? cond_eval(E_ifun, cc_reg) : 1'b0;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
    assign set_cc = (E_icode == I_OPQ) && !m_exc && !W_exc && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg <= 3'b100;
        end else if (set_cc) begin
            cc_reg <= {new_zf, new_sf, new_of};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_icode_reg <= BUB_ICODE;
            m_cnd_reg   <= BUB_CND;
            m_vale_reg  <= '0;
            m_vala_reg  <= '0;
            m_dste_reg  <= RNONE;
            m_dstm_reg  <= RNONE;
        end else if (!M_stall) begin
            if (M_bubble) begin
                m_icode_reg <= BUB_ICODE;
                m_cnd_reg   <= BUB_CND;
                m_vale_reg  <= '0;
                m_vala_reg  <= '0;
                m_dste_reg  <= RNONE;
                m_dstm_reg  <= RNONE;
            end else begin
                m_icode_reg <= E_icode;
                m_cnd_reg   <= e_Cnd;
                m_vale_reg  <= e_valE;
                m_vala_reg  <= E_valA;
                m_dste_reg  <= e_dstE;
                m_dstm_reg  <= E_dstM;
            end
        end
    end

`ifdef EXEC_PERF_EN
    logic [31:0] perf_opq_reg;
    logic [31:0] perf_cmov_sq_reg;
    logic        cmov_squash;

    assign cmov_squash = (E_icode == I_RRMOVQ) && !e_Cnd && (E_ifun != C_YES)
                         && !M_stall && !M_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_opq_reg     <= '0;
            perf_cmov_sq_reg <= '0;
        end else begin
            if (set_cc)
                perf_opq_reg <= perf_opq_reg + 32'd1;
            if (cmov_squash)
                perf_cmov_sq_reg <= perf_cmov_sq_reg + 32'd1;
        end
    end

    assign perf_opq     = perf_opq_reg;
    assign perf_cmov_sq = perf_cmov_sq_reg;
`endif

    assign cc      = cc_reg;
    assign M_icode = m_icode_reg;
    assign M_Cnd   = m_cnd_reg;
    assign M_valE  = m_vale_reg;
    assign M_valA  = m_vala_reg;
    assign M_dstE  = m_dste_reg;
    assign M_dstM  = m_dstm_reg;

endmodule

// File: tb/tb_exec_mreg_pipe.sv
// Self-checking bench for exec_mreg_pipe: vector table plus control-priority sequences,
// with expected M register contents queued at drive time and popped after each edge.
module tb_exec_mreg_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic        m_exc, W_exc, M_stall, M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [2:0]  cc;
`ifdef EXEC_PERF_EN
    logic [31:0] perf_opq, perf_cmov_sq;
`endif

    exec_mreg_pipe #(.W(64), .RNONE(4'hF)) dut (
        .clk      (clk),
        .rst      (rst),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_valC   (E_valC),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .m_exc    (m_exc),
        .W_exc    (W_exc),
        .M_stall  (M_stall),
        .M_bubble (M_bubble),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
`ifdef EXEC_PERF_EN
        .perf_opq     (perf_opq),
        .perf_cmov_sq (perf_cmov_sq),
`endif
        .cc       (cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] vc;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        mexc;
        logic        wexc;
        logic [63:0] exp_vale;
        logic        exp_cnd;
        logic [3:0]  exp_dste;
        logic [2:0]  exp_cc;
    } vec_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } mexp_t;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    vec_t  vecs[22];
    mexp_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                input logic [3:0] dste, input logic [3:0] dstm,
                                input logic mexc, input logic wexc,
                                input logic [63:0] exp_vale, input logic exp_cnd,
                                input logic [3:0] exp_dste, input logic [2:0] exp_cc);
        vec_t v;
        v.icode = icode; v.ifun = ifun; v.va = va; v.vb = vb; v.vc = vc;
        v.dste = dste; v.dstm = dstm; v.mexc = mexc; v.wexc = wexc;
        v.exp_vale = exp_vale; v.exp_cnd = exp_cnd; v.exp_dste = exp_dste; v.exp_cc = exp_cc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] dste, input logic [3:0] dstm,
                         input logic mexc, input logic wexc);
        @(negedge clk);
        E_icode = icode; E_ifun = ifun; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = dste; E_dstM = dstm; m_exc = mexc; W_exc = wexc;
        #1;
    endtask

    // Clock one edge, then pop the oldest expected M contents and compare.
    task automatic edge_check(input string tag, input logic [2:0] exp_cc);
        mexp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s sb_empty: got 0 entries, expected 1", tag);
        end else begin
            n_checks--;
            e = sb.pop_front();
            check({tag, " M_icode"}, 64'(M_icode), 64'(e.icode));
            check({tag, " M_Cnd"},   64'(M_Cnd),   64'(e.cnd));
            check({tag, " M_valE"},  M_valE,       e.vale);
            check({tag, " M_valA"},  M_valA,       e.vala);
            check({tag, " M_dstE"},  64'(M_dstE),  64'(e.dste));
            check({tag, " M_dstM"},  64'(M_dstM),  64'(e.dstm));
        end
        check({tag, " cc"}, 64'(cc), 64'(exp_cc));
        $display("%s: M_icode=%h M_valE=%h M_dstE=%h cc=%b", tag, M_icode, M_valE, M_dstE, cc);
    endtask

    initial begin
        //            icode ifun valA        valB        valC       dstE  dstM  mexc wexc exp_valE                  cnd  exp_dstE cc
        vecs[0]  = mk(4'h6, 4'h1, 64'd5,     64'd3,      64'h0,     4'h2, 4'hF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'h2, 3'b010);
        vecs[1]  = mk(4'h6, 4'h1, 64'd1,     MINN,       64'h0,     4'h2, 4'hF, 0, 0, MAXP,                    0, 4'h2, 3'b001);
        vecs[2]  = mk(4'h6, 4'h0, MAXP,      MAXP,       64'h0,     4'h1, 4'hF, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'h1, 3'b001);
        vecs[3]  = mk(4'h7, 4'h2, 64'h9,     64'h9,      64'h400,   4'hF, 4'hF, 0, 0, 64'h0,                   1, 4'hF, 3'b001);
        vecs[4]  = mk(4'h6, 4'h2, 64'hF0F0,  64'hFF00,   64'h0,     4'h4, 4'hF, 0, 0, 64'hF000,                0, 4'h4, 3'b000);
        vecs[5]  = mk(4'h2, 4'h1, 64'h55,    64'h99,     64'h0,     4'h3, 4'hF, 0, 0, 64'h55,                  0, 4'hF, 3'b000);
        vecs[6]  = mk(4'h6, 4'h3, 64'h1234,  64'h1234,   64'h0,     4'h5, 4'hF, 0, 0, 64'h0,                   0, 4'h5, 3'b100);
        vecs[7]  = mk(4'h2, 4'h1, 64'h77,    64'h99,     64'h0,     4'h3, 4'hF, 0, 0, 64'h77,                  1, 4'h3, 3'b100);
        vecs[8]  = mk(4'hA, 4'h0, 64'h33,    64'h100,    64'h0,     4'h4, 4'hF, 0, 0, 64'hF8,                  0, 4'h4, 3'b100);
        vecs[9]  = mk(4'hB, 4'h0, 64'h33,    64'h100,    64'h0,     4'h4, 4'h6, 0, 0, 64'h108,                 0, 4'h4, 3'b100);
        vecs[10] = mk(4'h3, 4'h0, 64'h0,     64'h999,    64'hABCD,  4'h7, 4'hF, 0, 0, 64'hABCD,                0, 4'h7, 3'b100);
        vecs[11] = mk(4'h5, 4'h0, 64'h0,     64'h20,     64'h10,    4'hF, 4'h8, 0, 0, 64'h30,                  0, 4'hF, 3'b100);
        vecs[12] = mk(4'h6, 4'h0, MAXP,      MAXP,       64'h0,     4'h1, 4'hF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'h1, 3'b011);
        vecs[13] = mk(4'h7, 4'h1, 64'h0,     64'h0,      64'h500,   4'hF, 4'hF, 0, 0, 64'h0,                   0, 4'hF, 3'b011);
        vecs[14] = mk(4'h7, 4'h6, 64'h0,     64'h0,      64'h500,   4'hF, 4'hF, 0, 0, 64'h0,                   1, 4'hF, 3'b011);
        vecs[15] = mk(4'h6, 4'h5, 64'd3,     64'd4,      64'h0,     4'h2, 4'hF, 0, 0, 64'h0,                   0, 4'h2, 3'b100);
        vecs[16] = mk(4'h7, 4'h3, 64'h0,     64'h0,      64'h600,   4'hF, 4'hF, 0, 0, 64'h0,                   1, 4'hF, 3'b100);
        vecs[17] = mk(4'h7, 4'h7, 64'h0,     64'h0,      64'h600,   4'hF, 4'hF, 0, 0, 64'h0,                   0, 4'hF, 3'b100);
        vecs[18] = mk(4'h6, 4'h1, 64'd1,     64'd0,      64'h0,     4'h2, 4'hF, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'h2, 3'b100);
        vecs[19] = mk(4'h7, 4'h4, 64'h0,     64'h0,      64'h700,   4'hF, 4'hF, 0, 0, 64'h0,                   0, 4'hF, 3'b100);
        vecs[20] = mk(4'h8, 4'h0, 64'h0,     64'h200,    64'h800,   4'h4, 4'hF, 0, 0, 64'h1F8,                 0, 4'h4, 3'b100);
        vecs[21] = mk(4'h9, 4'h0, 64'h0,     64'h200,    64'h0,     4'h4, 4'hF, 0, 0, 64'h208,                 0, 4'h4, 3'b100);

        // Reset with arbitrary E inputs present
        rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
        drive(4'h6, 4'h1, 64'hDEAD, 64'hBEEF, 64'h1, 4'h3, 4'h4, 0, 0);
        sb.push_back('{4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF});
        edge_check("reset", 3'b100);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].icode, vecs[i].ifun, vecs[i].va, vecs[i].vb, vecs[i].vc,
                  vecs[i].dste, vecs[i].dstm, vecs[i].mexc, vecs[i].wexc);
            check($sformatf("vec%0d e_valE", i), e_valE,       vecs[i].exp_vale);
            check($sformatf("vec%0d e_Cnd", i),  64'(e_Cnd),   64'(vecs[i].exp_cnd));
            check($sformatf("vec%0d e_dstE", i), 64'(e_dstE),  64'(vecs[i].exp_dste));
            sb.push_back('{vecs[i].icode, vecs[i].exp_cnd, vecs[i].exp_vale, vecs[i].va,
                           vecs[i].exp_dste, vecs[i].dstm});
            edge_check($sformatf("vec%0d", i), vecs[i].exp_cc);
        end

        // Control priority: load, stall+bubble holds (CC still updates), bubble, load, reset-during-stall
        drive(4'h3, 4'h0, 64'h11, 64'h0, 64'h42, 4'h5, 4'hF, 0, 0);
        sb.push_back('{4'h3, 1'b0, 64'h42, 64'h11, 4'h5, 4'hF});
        edge_check("seq_load", 3'b100);

        M_stall = 1'b1; M_bubble = 1'b1;
        drive(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'h9, 0, 0);
        sb.push_back('{4'h3, 1'b0, 64'h42, 64'h11, 4'h5, 4'hF});
        edge_check("seq_stall_bubble", 3'b010);

        M_stall = 1'b0; M_bubble = 1'b1;
        drive(4'h7, 4'h0, 64'h66, 64'h0, 64'h900, 4'hF, 4'hF, 0, 0);
        sb.push_back('{4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF});
        edge_check("seq_bubble", 3'b010);

        M_bubble = 1'b0;
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h6, 4'hF, 0, 0);
        sb.push_back('{4'h6, 1'b0, 64'h3, 64'h1, 4'h6, 4'hF});
        edge_check("seq_load2", 3'b000);

        rst = 1'b1; M_stall = 1'b1;
        drive(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'h9, 0, 0);
        sb.push_back('{4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF});
        edge_check("seq_rst_stall", 3'b100);
        rst = 1'b0; M_stall = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
